// File: rtl/voice_alloc_if.sv
// Key-event handshake bundle between the event source and the voice allocator.
// The source drives valid/on/noteid; the allocator answers with ready.
interface voice_alloc_if;
  logic       ev_valid;
  logic       ev_ready;
  logic       ev_on;
  logic [7:0] ev_noteid;

  modport master (output ev_valid, output ev_on, output ev_noteid, input ev_ready);
  modport slave  (input ev_valid, input ev_on, input ev_noteid, output ev_ready);
endinterface

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps key events onto NUM_VOICES note voices.
// Each accepted event is scanned against all voices (one per cycle), then
// committed in a single cycle: re-strike, free-voice allocation or steal of
// the oldest voice for note-on; release of the matching voice for note-off.
// Optional macro SUSTAIN_PEDAL_EN adds a sustain input that holds released
// voices until the pedal falls.
//
// state  | meaning
// IDLE   | ready for an event; pending sustain release applied here
// SCAN   | examine voice idx, record match / free / oldest candidates
// COMMIT | apply the recorded decision to the voice bank
module voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
`ifdef SUSTAIN_PEDAL_EN
  input  logic                    sustain,
`endif
  voice_alloc_if.slave            ev,
  output logic [NUM_VOICES*8-1:0] voice_noteid,
  output logic [NUM_VOICES-1:0]   voice_active,
  output logic [NUM_VOICES-1:0]   retrig,
  output logic                    busy
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx, match_idx, free_idx, oldest_idx, tgt_idx;
  logic             match_found, free_found, oldest_found;
  logic [AGE_W-1:0] oldest_age;
  logic             lat_on;
  logic [7:0]       lat_note;
  logic [7:0]       note_q [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];
  logic             accept;
  logic             rel_block;

`ifdef SUSTAIN_PEDAL_EN
  logic                  sus_q, sus_qq, rel_pend, sus_fall, rel_now;
  logic [NUM_VOICES-1:0] held;

  // Pedal release is detected on registered samples and may be deferred
  // until the FSM is back in IDLE; it also blocks acceptance that cycle.
  assign sus_fall  = sus_qq & ~sus_q;
  assign rel_block = sus_fall | rel_pend;
  assign rel_now   = rel_block && (state == IDLE);
`else
  assign rel_block = 1'b0;
`endif

  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and handshake; noteid 0 is accepted but never leaves IDLE.
  always_comb begin
    state_nx    = state;
    ev.ev_ready = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        ev.ev_ready = ~rst & ~rel_block;
        accept      = ev.ev_valid & ~rst & ~rel_block & (ev.ev_noteid != 8'd0);
        if (accept) state_nx = SCAN;
      end
      SCAN:    if (idx == LAST_IDX) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Voice receiving the note-on: re-struck match, else lowest free, else oldest.
  always_comb begin
    tgt_idx = oldest_idx;
    if (match_found)     tgt_idx = match_idx;
    else if (free_found) tgt_idx = free_idx;
  end

  // Flatten the per-voice note registers onto the output bus.
  always_comb begin
    voice_noteid = '0;
    for (int i = 0; i < NUM_VOICES; i++) voice_noteid[i*8 +: 8] = note_q[i];
  end

  // Event latch, scan bookkeeping and commit of the voice bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx          <= '0;
      match_idx    <= '0;
      free_idx     <= '0;
      oldest_idx   <= '0;
      match_found  <= 1'b0;
      free_found   <= 1'b0;
      oldest_found <= 1'b0;
      oldest_age   <= '0;
      lat_on       <= 1'b0;
      lat_note     <= '0;
      voice_active <= '0;
      retrig       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_q[i] <= '0;
        age_q[i]  <= '0;
      end
`ifdef SUSTAIN_PEDAL_EN
      sus_q    <= 1'b0;
      sus_qq   <= 1'b0;
      rel_pend <= 1'b0;
      held     <= '0;
`endif
    end else begin
      retrig <= '0;
`ifdef SUSTAIN_PEDAL_EN
      sus_q    <= sustain;
      sus_qq   <= sus_q;
      rel_pend <= rel_block & ~rel_now;
      if (rel_now) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (held[i]) begin
            note_q[i]       <= '0;
            voice_active[i] <= 1'b0;
            age_q[i]        <= '0;
            held[i]         <= 1'b0;
          end
        end
      end
`endif
      if (accept) begin
        lat_on       <= ev.ev_on;
        lat_note     <= ev.ev_noteid;
        idx          <= '0;
        match_found  <= 1'b0;
        free_found   <= 1'b0;
        oldest_found <= 1'b0;
        oldest_age   <= '0;
      end

      if (state == SCAN) begin
        idx <= idx + 1'b1;
        if (!match_found && voice_active[idx] && (note_q[idx] == lat_note)) begin
          match_found <= 1'b1;
          match_idx   <= idx;
        end
        if (!free_found && !voice_active[idx]) begin
          free_found <= 1'b1;
          free_idx   <= idx;
        end
        // Strictly greater keeps the lowest index on equal ages.
        if (voice_active[idx] && (!oldest_found || (age_q[idx] > oldest_age))) begin
          oldest_found <= 1'b1;
          oldest_idx   <= idx;
          oldest_age   <= age_q[idx];
        end
      end

      if (state == COMMIT) begin
        if (lat_on) begin
          if (match_found) begin
            retrig[match_idx] <= 1'b1;
`ifdef SUSTAIN_PEDAL_EN
            held[match_idx] <= 1'b0;
`endif
          end else if (free_found) begin
            note_q[free_idx]       <= lat_note;
            voice_active[free_idx] <= 1'b1;
          end else begin
            note_q[oldest_idx] <= lat_note;
            retrig[oldest_idx] <= 1'b1;
`ifdef SUSTAIN_PEDAL_EN
            held[oldest_idx] <= 1'b0;
`endif
          end
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == tgt_idx)   age_q[i] <= '0;
            else if (!voice_active[i])  age_q[i] <= '0;
            else if (age_q[i] != '1)    age_q[i] <= age_q[i] + 1'b1;
          end
        end else if (match_found) begin
`ifdef SUSTAIN_PEDAL_EN
          if (sustain) begin
            held[match_idx] <= 1'b1;
          end else begin
            note_q[match_idx]       <= '0;
            voice_active[match_idx] <= 1'b0;
            age_q[match_idx]        <= '0;
            held[match_idx]         <= 1'b0;
          end
`else
          note_q[match_idx]       <= '0;
          voice_active[match_idx] <= 1'b0;
          age_q[match_idx]        <= '0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Self-checking bench for voice_alloc: directed scenarios plus randomized
// events, compared every cycle against an array-based model of the voice bank.
module tb_voice_alloc;
  localparam int N    = 4;
  localparam int AW   = 3;
  localparam int MAXA = (1 << AW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

`ifdef SUSTAIN_PEDAL_EN
  logic sustain = 1'b0;
`endif

  voice_alloc_if ifc();
  logic [N*8-1:0] voice_noteid;
  logic [N-1:0]   voice_active, retrig;
  logic           busy;

  voice_alloc #(.NUM_VOICES(N), .AGE_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
`ifdef SUSTAIN_PEDAL_EN
    .sustain      (sustain),
`endif
    .ev           (ifc),
    .voice_noteid (voice_noteid),
    .voice_active (voice_active),
    .retrig       (retrig),
    .busy         (busy)
  );

  int checks = 0;
  int errors = 0;

  // model of the voice bank
  int m_note [N];
  bit m_act  [N];
  int m_age  [N];
  bit m_held [N];

  logic [N*8-1:0] exp_noteid;
  logic [N-1:0]   exp_active, exp_retrig, last_pulse;
  logic           exp_busy, exp_ready;
  bit             chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("noteid", voice_noteid, exp_noteid);
      check("active", voice_active, exp_active);
      check("retrig", retrig, exp_retrig);
      check("busy", busy, exp_busy);
      check("ready", ifc.ev_ready, exp_ready);
    end
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_note[i] = 0; m_act[i] = 0; m_age[i] = 0; m_held[i] = 0;
    end
  endtask

  task automatic update_exp();
    for (int i = 0; i < N; i++) begin
      exp_noteid[i*8 +: 8] = 8'(m_note[i]);
      exp_active[i]        = m_act[i];
    end
  endtask

  task automatic model_apply(input bit on, input int note, input bit sus, output logic [N-1:0] pulse);
    int match, free, old, t;
    match = -1; free = -1; old = -1; pulse = '0;
    for (int i = 0; i < N; i++) begin
      if (match < 0 && m_act[i] && m_note[i] == note) match = i;
      if (free < 0 && !m_act[i]) free = i;
      if (m_act[i] && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    if (on) begin
      if (match >= 0) begin
        t = match; pulse[t] = 1'b1; m_held[t] = 0;
      end else if (free >= 0) begin
        t = free; m_note[t] = note; m_act[t] = 1;
      end else begin
        t = old; m_note[t] = note; pulse[t] = 1'b1; m_held[t] = 0;
      end
      for (int i = 0; i < N; i++) begin
        if (i == t)          m_age[i] = 0;
        else if (!m_act[i])  m_age[i] = 0;
        else if (m_age[i] < MAXA) m_age[i] = m_age[i] + 1;
      end
    end else if (match >= 0) begin
      if (sus) m_held[match] = 1;
      else begin
        m_note[match] = 0; m_act[match] = 0; m_age[match] = 0; m_held[match] = 0;
      end
    end
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    ifc.ev_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    update_exp();
    exp_retrig = '0; exp_busy = 1'b0; exp_ready = 1'b1;
    chk_en = 1'b1;
  endtask

  task automatic send(input bit on, input logic [7:0] note);
    logic [N-1:0] pulse;
    bit sus;
    ifc.ev_valid = 1'b1; ifc.ev_on = on; ifc.ev_noteid = note;
    @(posedge clk); #1;
    ifc.ev_valid = 1'b0;
    if (note == 8'd0) return;
    sus = 1'b0;
`ifdef SUSTAIN_PEDAL_EN
    sus = sustain;
`endif
    model_apply(on, int'(note), sus, pulse);
    exp_busy = 1'b1; exp_ready = 1'b0;
    repeat (N) begin
      ifc.ev_valid  = 1'($urandom);
      ifc.ev_on     = 1'($urandom);
      ifc.ev_noteid = 8'($urandom);
      @(posedge clk); #1;
    end
    ifc.ev_valid = 1'b0;
    @(posedge clk); #1;
    update_exp();
    exp_retrig = pulse; exp_busy = 1'b0; exp_ready = 1'b1;
    last_pulse = pulse;
    @(posedge clk); #1;
    exp_retrig = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    ifc.ev_valid = 1'b0; ifc.ev_on = 1'b0; ifc.ev_noteid = 8'd0;
    exp_noteid = '0; exp_active = '0; exp_retrig = '0; last_pulse = '0;
    exp_busy = 1'b0; exp_ready = 1'b0;
    model_reset();
    #2;
    check("rst_noteid", voice_noteid, 0);
    check("rst_active", voice_active, 0);
    check("rst_retrig", retrig, 0);
    check("rst_ready", ifc.ev_ready, 0);
    check("rst_busy", busy, 0);
    do_reset();

    // first note-on and re-strike
    send(1'b1, 8'd60);
    check("t1_v0", voice_noteid[7:0], 60);
    check("t1_act", voice_active, 4'b0001);
    send(1'b1, 8'd60);
    check("t2_pulse", last_pulse, 4'b0001);
    check("t2_act", voice_active, 4'b0001);

    // steal of the oldest voice
    do_reset();
    send(1'b1, 8'd60); send(1'b1, 8'd62); send(1'b1, 8'd64); send(1'b1, 8'd65);
    send(1'b1, 8'd67);
    check("steal_bank", voice_noteid, 32'h41403E43);
    check("steal_pulse", last_pulse, 4'b0001);
    check("steal_model", m_note[0], 67);

    // lowest free voice reuse, absent note-off
    do_reset();
    send(1'b1, 8'd60); send(1'b1, 8'd62); send(1'b0, 8'd60); send(1'b1, 8'd64);
    check("free_bank", voice_noteid[15:0], 16'h3E40);
    check("free_act", voice_active, 4'b0011);
    send(1'b0, 8'd70);
    check("absent_bank", voice_noteid[15:0], 16'h3E40);
    check("absent_act", voice_active, 4'b0011);

    // dropped event, then reset in the middle of a scan
    do_reset();
    send(1'b1, 8'd0);
    check("drop_act", voice_active, 0);
    ifc.ev_valid = 1'b1; ifc.ev_on = 1'b1; ifc.ev_noteid = 8'd72;
    @(posedge clk); #1;
    ifc.ev_valid = 1'b0;
    exp_busy = 1'b1; exp_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("midrst_noteid", voice_noteid, 0);
    check("midrst_active", voice_active, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ready", ifc.ev_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("postrst_ready", ifc.ev_ready, 1);
    check("postrst_noteid", voice_noteid, 0);
    check("postrst_retrig", retrig, 0);
    model_reset(); update_exp();
    exp_retrig = '0; exp_busy = 1'b0; exp_ready = 1'b1;
    chk_en = 1'b1;
    // must not have committed the aborted note
    repeat (N + 2) begin @(posedge clk); #1; end

`ifdef SUSTAIN_PEDAL_EN
    do_reset();
    sustain = 1'b1;
    send(1'b1, 8'd60);
    send(1'b0, 8'd60);
    check("sus_hold_note", voice_noteid[7:0], 60);
    check("sus_hold_act", voice_active, 4'b0001);
    chk_en = 1'b0;
    sustain = 1'b0;
    for (int k = 0; k < 8 && voice_active[0]; k++) begin @(posedge clk); #1; end
    check("sus_release_act", voice_active, 0);
    check("sus_release_note", voice_noteid, 0);
    for (int i = 0; i < N; i++) if (m_held[i]) begin
      m_note[i] = 0; m_act[i] = 0; m_age[i] = 0; m_held[i] = 0;
    end
    update_exp();
    @(posedge clk); #1;
    chk_en = 1'b1;
`endif

    // randomized traffic over a small note range to force matches and steals
    do_reset();
    for (int n = 0; n < 400; n++) begin
      send(($urandom % 10) < 6, 8'($urandom % 12));
      repeat ($urandom % 2) begin @(posedge clk); #1; end
    end
    repeat (2) begin @(posedge clk); #1; end
    chk_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
Polyphonic voice allocator. It sits between the keyboard/sequencer event source and a bank of NUM_VOICES note synthesizer instances. Each accepted key event is mapped onto one voice, and the block drives that voice's 8-bit noteid, where 0 means silence. The datapath runs in the same clk domain as the note instances, at 120 MHz.

Parameters:
NUM_VOICES, 4, number of note instances driven (2..16)
AGE_W, 8, width of per-voice age counter (saturating)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
ev_valid  in  1  key event present
ev_ready  out  1  block can accept event this cycle
ev_on  in  1  1 = note-on, 0 = note-off
ev_noteid  in  8  note number of event
voice_noteid  out  NUM_VOICES*8  noteid per voice; voice i at bits [i*8+:8]
voice_active  out  NUM_VOICES  1 = voice i holds a note
retrig  out  NUM_VOICES  one-cycle pulse: voice i re-struck with same note
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst=1): voice_noteid=0, voice_active=0, retrig=0, all ages=0, state IDLE, ev_ready=0 while rst high.
- Handshake: ev_ready=1 only in IDLE. Event is accepted on a rising edge with ev_valid&ev_ready. ev_on/ev_noteid are latched at accept.
- Events with ev_noteid==0 are accepted and dropped, with no state change. The FSM stays in IDLE.
- FSM states:
  - IDLE: accept event, then go to SCAN with idx=0.
  - SCAN: examine voice idx, one voice per cycle, for NUM_VOICES cycles, then go to COMMIT.
  - COMMIT: apply the result, then go to IDLE.
- Latency: accepted at edge k; outputs update at edge k+NUM_VOICES+1; ev_ready high again after that edge.
- SCAN records three things:
  - match = lowest idx with voice_active and noteid==latched note.
  - free = lowest idx with !voice_active.
  - oldest = idx with max age among active voices; ties go to the lowest idx.
- COMMIT, note-on:
  - If match exists: voice unchanged except age[match]=0; retrig[match]=1 for exactly one cycle.
  - Else if free exists: voice_noteid[free]=note, voice_active[free]=1, age=0.
  - Else (steal): voice_noteid[oldest]=note, age[oldest]=0, retrig[oldest]=1.
  - Every other active voice: age+1, saturating at 2^AGE_W-1. Inactive voice ages are held at 0.
- COMMIT, note-off:
  - If match exists: voice_noteid[match]=0, voice_active[match]=0, age=0.
  - Else: no change. Ages do not advance on note-off.
- retrig is 0 in all cycles other than the COMMIT-following cycle it is asserted in.
- ev_valid toggling while busy is ignored; no event is lost, because ev_ready=0 holds it off.
- rst asserted mid-SCAN/COMMIT: immediate return to reset values. The partially processed event is discarded.
- At most one voice ever holds a given nonzero noteid.

Optional Feature:
SUSTAIN_PEDAL_EN.
- Defined: adds input port sustain (1 bit) and an internal held[NUM_VOICES].
  - Note-off matching a voice while sustain=1 sets held[match]=1. The voice stays active.
  - Note-on matching a held voice clears held and retriggers.
  - A falling edge of sustain (registered, detected in clk domain) releases all held voices: noteid=0, active=0, held=0. The release happens in a single cycle while in IDLE.
  - If the falling edge occurs while busy, the release is deferred to the first IDLE cycle. Event acceptance is blocked (ev_ready=0) in that release cycle.
  - Held voices remain steal candidates by age.
- Undefined: no sustain port; note-off always frees immediately.

Test Plan:
- Reset, then note-on 60 -> ev_ready drops for NUM_VOICES+1 cycles (5 with default NUM_VOICES=4); voice0 noteid=60, voice_active=4'b0001, retrig=0.
- Note-on 60,62,64,65 then note-on 67 -> voices 0..3 = 60,62,64,65; voice0 (oldest) stolen, becomes 67 with a retrig[0] pulse; others unchanged.
- Note-on 60, note-on 60 again -> single voice, noteid 60, retrig[0] one-cycle pulse, voice_active=4'b0001.
- Note-on 60,62, note-off 60, note-on 64 -> 64 lands in voice0 (lowest free); note-off 70 (absent) -> no output change.
- Event ev_noteid=0, then assert rst mid-SCAN of note-on 72 -> no voice change for the first event; after rst all outputs 0 and ev_ready=1 one cycle after rst falls.
- (SUSTAIN_PEDAL_EN) sustain=1, note-on 60, note-off 60 -> voice0 still 60; sustain falls -> voice0 noteid=0, active=0 within 2 cycles of IDLE.
